// File: rtl/rot_word_pipe_pkg.sv
// Shared key-expander constants: rotation direction encoding and default widths.
// Also provides a small helper for deriving byte counts from word widths.
package rot_word_pipe_pkg;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  localparam int DEFAULT_WORD_W  = 32;
  localparam int DEFAULT_ROUND_W = 4;
  localparam int DEFAULT_AMT_W   = 4;

  function automatic int byte_count(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/rot_word_bytes.sv
// Combinational byte rotation of a word, left (towards MSB) or right.
// The amount is taken modulo the number of bytes in the word.
module rot_word_bytes
  import rot_word_pipe_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int AMT_W  = DEFAULT_AMT_W
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              dir_i,
  output logic [WORD_W-1:0] word_o
);

  localparam int NBYTES = byte_count(WORD_W);
  localparam int SH_W   = $clog2(NBYTES);

  logic [SH_W-1:0] amt_eff;

  // NBYTES is a power of two, so truncating the amount is the modulo.
  assign amt_eff = SH_W'(amt_i);

  always_comb begin
    logic [SH_W-1:0] src;
    // NOTE: every variable gets a default before any conditional logic, so no
    // path leaves it unassigned and no latch is inferred.
    src    = '0;
    word_o = '0;
    for (int i = 0; i < NBYTES; i++) begin
      src = (dir_i == ROT_LEFT) ? SH_W'(i) - amt_eff : SH_W'(i) + amt_eff;
      word_o[i*8 +: 8] = word_i[src*8 +: 8];
    end
  end

endmodule

// File: rtl/rot_word_pipe.sv
// Pipelined byte-rotation stage for the AES key expander with valid/ready on
// both sides; rotation happens before stage 0 and the round tag rides along.
module rot_word_pipe
  import rot_word_pipe_pkg::*;
#(
  parameter int WORD_W  = DEFAULT_WORD_W,
  parameter int ROUND_W = DEFAULT_ROUND_W,
  parameter int AMT_W   = DEFAULT_AMT_W,
  parameter int STAGES  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_word,
  input  logic [ROUND_W-1:0]           in_round,
  input  logic [AMT_W-1:0]             in_amt,
  input  logic                         in_dir,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_word,
  output logic [ROUND_W-1:0]           out_round,
  output logic [$clog2(STAGES+1)-1:0]  inflight
);

  localparam int CNT_W = $clog2(STAGES + 1);

  logic [WORD_W-1:0]  rot_word;

  logic               v_q     [STAGES];
  logic               v_d     [STAGES];
  logic [WORD_W-1:0]  word_q  [STAGES];
  logic [WORD_W-1:0]  word_d  [STAGES];
  logic [ROUND_W-1:0] round_q [STAGES];
  logic [ROUND_W-1:0] round_d [STAGES];

  logic               src_v     [STAGES];
  logic [WORD_W-1:0]  src_word  [STAGES];
  logic [ROUND_W-1:0] src_round [STAGES];
  logic [STAGES:0]    ready;

  rot_word_bytes #(
    .WORD_W (WORD_W),
    .AMT_W  (AMT_W)
  ) u_rot (
    .word_i (in_word),
    .amt_i  (in_amt),
    .dir_i  (in_dir),
    .word_o (rot_word)
  );

  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    // A stage can load when empty or when its occupant moves on this cycle.
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = ~v_q[k] | ready[k+1];
    end

    src_v[0]     = in_valid & ~rst;
    src_word[0]  = rot_word;
    src_round[0] = in_round;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]     = v_q[k-1];
      src_word[k]  = word_q[k-1];
      src_round[k] = round_q[k-1];
    end

    // Data registers only capture a real transfer; bubbles leave them untouched.
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]     = ready[k] ? src_v[k] : v_q[k];
      word_d[k]  = (ready[k] & src_v[k]) ? src_word[k]  : word_q[k];
      round_d[k] = (ready[k] & src_v[k]) ? src_round[k] : round_q[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every stage
      // samples the pre-edge value of its neighbour, whatever the block order.
      if (rst) begin
        v_q[k]     <= 1'b0;
        // NOTE: data registers are reset too, because out_word/out_round must
        // read zero after reset rather than stale contents.
        word_q[k]  <= '0;
        round_q[k] <= '0;
      end else begin
        v_q[k]     <= v_d[k];
        word_q[k]  <= word_d[k];
        round_q[k] <= round_d[k];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++) begin
      inflight = inflight + CNT_W'(v_q[k]);
    end
  end

  assign in_ready  = ready[0] & ~rst;
  assign out_valid = v_q[STAGES-1];
  assign out_word  = word_q[STAGES-1];
  assign out_round = round_q[STAGES-1];

endmodule

// File: tb/tb_rot_word_pipe.sv
// Scoreboard bench for rot_word_pipe: a 32-bit/2-stage instance under random
// backpressure and reset, plus a 64-bit/1-stage instance for the wide case.
module tb_rot_word_pipe;
  import rot_word_pipe_pkg::*;

  localparam int W    = 32;
  localparam int RW   = 4;
  localparam int AW   = 4;
  localparam int ST   = 2;
  localparam int W_B  = 64;
  localparam int ST_B = 1;

  logic clk;
  logic rst;

  logic                      in_valid, in_ready, in_dir, out_valid, out_ready;
  logic [W-1:0]              in_word, out_word;
  logic [RW-1:0]             in_round, out_round;
  logic [AW-1:0]             in_amt;
  logic [$clog2(ST+1)-1:0]   inflight;

  logic                      b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready;
  logic [W_B-1:0]            b_in_word, b_out_word;
  logic [RW-1:0]             b_in_round, b_out_round;
  logic [AW-1:0]             b_in_amt;
  logic [$clog2(ST_B+1)-1:0] b_inflight;

  typedef struct packed {
    logic [63:0]   w;
    logic [RW-1:0] r;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_b_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  int b2b_first;
  int last_pop;
  logic b2b_arm = 1'b0;
  logic bp_mode = 1'b0;
  logic ready_level = 1'b1;

  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_word;
  logic [RW-1:0] prev_round;
  exp_t          mon_e;
  exp_t          mon_b_e;

  rot_word_pipe #(.WORD_W(W), .ROUND_W(RW), .AMT_W(AW), .STAGES(ST)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_round  (in_round),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_round (out_round),
    .inflight  (inflight)
  );

  rot_word_pipe #(.WORD_W(W_B), .ROUND_W(RW), .AMT_W(AW), .STAGES(ST_B)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_word   (b_in_word),
    .in_round  (b_in_round),
    .in_amt    (b_in_amt),
    .in_dir    (b_in_dir),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_word  (b_out_word),
    .out_round (b_out_round),
    .inflight  (b_inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Byte rotation as whole-word shifts; right by a equals left by NBYTES-a.
  function automatic logic [63:0] rot_ref(input logic [63:0] w, input int width,
                                          input int amt, input logic dir);
    int n, a;
    logic [63:0] mask;
    n    = width / 8;
    a    = amt % n;
    if (dir == ROT_RIGHT) a = (n - a) % n;
    mask = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
    w    = w & mask;
    if (a == 0) return w;
    return ((w << (8 * a)) | (w >> (width - 8 * a))) & mask;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_word", out_word, prev_word);
        check("stall_round", out_round, prev_round);
      end
      check("inflight_max", inflight <= ST, 1);
      check("in_ready_rule", in_ready, !(inflight == ST && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h round %0h required none", out_word, out_round);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_word", out_word, mon_e.w);
          check("out_round", out_round, mon_e.r);
        end
        n_out++;
        if (b2b_arm && b2b_first < 0) b2b_first = cyc;
        last_pop = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
      prev_round = out_round;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output_b: got %0h required none", b_out_word);
      end else begin
        mon_b_e = exp_b_q.pop_front();
        check("b_out_word", b_out_word, mon_b_e.w);
        check("b_out_round", b_out_round, mon_b_e.r);
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input logic [RW-1:0] r, input logic [AW-1:0] a,
                      input logic d, input logic [W-1:0] want);
    int   waited;
    exp_t e;
    in_valid = 1'b1;
    in_word  = w;
    in_round = r;
    in_amt   = a;
    in_dir   = d;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready 0 required 1");
    end else begin
      e.w = 64'(want);
      e.r = r;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [W_B-1:0] w, input logic [RW-1:0] r, input logic [AW-1:0] a,
                        input logic d, input logic [W_B-1:0] want);
    int   waited;
    exp_t e;
    b_in_valid = 1'b1;
    b_in_word  = w;
    b_in_round = r;
    b_in_amt   = a;
    b_in_dir   = d;
    waited     = 0;
    @(negedge clk);
    while (!b_in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!b_in_ready) begin
      total++;
      bad++;
      $display("FAIL send_b_timeout: in_ready 0 required 1");
    end else begin
      e.w = want;
      e.r = r;
      exp_b_q.push_back(e);
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_a", exp_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            n, start, n_start;
    logic [W-1:0]  w;
    logic [W_B-1:0] wb;
    logic [AW-1:0] a;
    logic          d;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_word    = '0;
    in_round   = '0;
    in_amt     = '0;
    in_dir     = ROT_LEFT;
    b_in_valid = 1'b0;
    b_in_word  = '0;
    b_in_round = '0;
    b_in_amt   = '0;
    b_in_dir   = ROT_LEFT;
    b_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_word", out_word, 0);
    check("reset_out_round", out_round, 0);
    check("reset_inflight", inflight, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_b_out_valid", b_out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Unstalled latency from the accepting cycle to out_valid.
    send(32'h01020304, 4'd3, 4'd1, ROT_LEFT, 32'h02030401);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency", n, ST);
    @(posedge clk);
    #1;
    wait_drain();

    send(32'h01020304, 4'd1, 4'd1, ROT_RIGHT, 32'h04010203);
    send(32'h01020304, 4'd2, 4'd4, ROT_LEFT,  32'h01020304);
    send(32'h01020304, 4'd4, 4'd0, ROT_LEFT,  32'h01020304);
    send(32'h01020304, 4'd5, 4'd5, ROT_LEFT,  32'h02030401);
    send(32'h01020304, 4'd6, 4'd6, ROT_RIGHT, 32'h03040102);
    send(32'h01020304, 4'd7, 4'd4, ROT_RIGHT, 32'h01020304);
    wait_drain();

    b2b_arm   = 1'b1;
    b2b_first = -1;
    start     = cyc;
    n_start   = n_out;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      a = AW'($urandom_range(0, 15));
      d = 1'($urandom_range(0, 1));
      send(w, RW'(i), a, d, W'(rot_ref(64'(w), W, int'(a), d)));
    end
    check("b2b_accept_cycles", cyc - start, 16);
    wait_drain();
    check("b2b_outputs", n_out - n_start, 16);
    check("b2b_spacing", last_pop - b2b_first, 15);
    b2b_arm = 1'b0;

    bp_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      w = $urandom;
      a = AW'($urandom_range(0, 15));
      d = 1'($urandom_range(0, 1));
      send(w, RW'($urandom_range(0, 15)), a, d, W'(rot_ref(64'(w), W, int'(a), d)));
    end
    bp_mode     = 1'b0;
    ready_level = 1'b1;
    idle(1);
    wait_drain();

    // Fill the pipe while stalled, then reset and confirm the words are flushed.
    ready_level = 1'b0;
    idle(2);
    send(32'hDEADBEEF, 4'd9, 4'd1, ROT_LEFT, 32'hADBEEFDE);
    send(32'hCAFEF00D, 4'd10, 4'd2, ROT_RIGHT, 32'hF00DCAFE);
    @(negedge clk);
    check("rst_pre_inflight", inflight, ST);
    ready_level = 1'b1;
    n_start = n_out;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_round", out_round, 0);
    check("rst_inflight", inflight, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    check("flush_no_output", n_out - n_start, 0);
    send(32'hA1B2C3D4, 4'd5, 4'd2, ROT_LEFT, 32'hC3D4A1B2);
    wait_drain();

    send_b(64'h0102030405060708, 4'd7, 4'd3, ROT_LEFT,  64'h0405060708010203);
    send_b(64'h0102030405060708, 4'd8, 4'd1, ROT_RIGHT, 64'h0801020304050607);
    send_b(64'h0102030405060708, 4'd9, 4'd8, ROT_LEFT,  64'h0102030405060708);
    for (int i = 0; i < 6; i++) begin
      wb = {$urandom, $urandom};
      a  = AW'($urandom_range(0, 15));
      d  = 1'($urandom_range(0, 1));
      send_b(wb, RW'(i), a, d, rot_ref(wb, W_B, int'(a), d));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
